// File: rtl/handshake_arb_pkg.sv
// Shared types and constants for the handshake round-robin arbiter.
package handshake_arb_pkg;

  localparam int N_DEFAULT     = 3;
  localparam int WIDTH_DEFAULT = 4;

  localparam logic [7:0] STALL_MAX = 8'hFF;

  typedef logic [1:0] grant_id_t;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first asserted req searching upward from
// (last_grant+1) mod N, wrapping.
module rr_priority_pick
  import handshake_arb_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant
);

  logic [IDW-1:0] cand_idx [N];
  logic [N-1:0]   cand_hit;

  // Slot gi of the search order is the requester gi+1 places after last_grant.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      localparam int OFFSET = gi + 1;
      assign cand_idx[gi] = IDW'((int'(last_grant) + OFFSET) % N);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_valid = 1'b1;
        grant       = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter feeding a single registered output slot with a stall counter.
// Define HANDSHAKE_RR_ARBITER_ASSERT_EN to include the protocol assertions and covers.
module handshake_rr_arbiter
  import handshake_arb_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int IDW   = $clog2(N)
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*WIDTH-1:0] req_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDW-1:0]     out_id,
  output logic [7:0]         stall_cnt
);

  slot_state_e      state_reg, state_next;
  logic [WIDTH-1:0] data_reg;
  logic [IDW-1:0]   id_reg;
  logic [IDW-1:0]   last_grant_reg;
  logic [7:0]       stall_cnt_reg;

  logic             grant_valid;
  logic [IDW-1:0]   grant;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] lane_data [N];

  rr_priority_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req         (req_valid),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign out_valid  = (state_reg == SLOT_FULL);
  assign can_accept = !out_valid || out_ready;
  // Gated by reset so no requester sees ready while the slot is held cleared.
  assign accept     = ASYNCRESETN && can_accept && grant_valid;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lane_data[gi] = req_data[gi*WIDTH +: WIDTH];
      assign req_ready[gi] = accept && (grant == IDW'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SLOT_EMPTY: if (accept) state_next = SLOT_FULL;
      SLOT_FULL:  if (out_ready && !accept) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_reg      <= SLOT_EMPTY;
      data_reg       <= '0;
      id_reg         <= '0;
      last_grant_reg <= IDW'(N - 1);
      stall_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        data_reg       <= lane_data[grant];
        id_reg         <= grant;
        last_grant_reg <= grant;
      end
      if (out_valid && !out_ready && (stall_cnt_reg != STALL_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + 8'd1;
      end
    end
  end

  assign out_data  = data_reg;
  assign out_id    = id_reg;
  assign stall_cnt = stall_cnt_reg;

`ifdef HANDSHAKE_RR_ARBITER_ASSERT_EN
  a_ready_onehot: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    $onehot0(req_ready));

  a_slot_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    out_valid && !out_ready |=> $stable(out_data) && $stable(out_id) && out_valid);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_sva
      a_hold_valid: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        req_valid[gi] && !req_ready[gi] |=> req_valid[gi]);
      c_granted: cover property (@(posedge CLK) disable iff (!ASYNCRESETN)
        req_valid[gi] && req_ready[gi]);
    end
  endgenerate
`else
  // Checks compiled out; datapath above is unaffected.
`endif

endmodule
